// File: rtl/pc_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory request/response,
// decode handoff, and redirect inputs from execute.
// master = fetch controller side, slave = surrounding pipeline/memory.
interface pc_fetch_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] pc_plus_imm;
    logic [31:0] alu_out;
    logic        pc_misaligned;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, pc_misaligned,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
               redirect_valid, pc_sel, branch_taken, pc_plus_imm, alu_out
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, pc_misaligned,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
               redirect_valid, pc_sel, branch_taken, pc_plus_imm, alu_out
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time,
// hands fetched words to decode and applies redirects from execute.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset release; responses ignored
// REQ   | imem request held valid at pc until accepted
// WAIT  | request accepted, waiting for the response word
// OUT   | fetched word presented to decode, held until taken or killed
//
// kill marks the in-flight request as wrong-path; pend_pc is where to
// resume once its response has been swallowed.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          ALIGN_JALR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        kill;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic        misaligned_q;

    logic        redir;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;

    // Decode the execute resolution into an effective redirect and its aligned target.
    always_comb begin
        redir = bus.redirect_valid &
                ((bus.pc_sel == 2'b01) | (bus.pc_sel == 2'b10) |
                 ((bus.pc_sel == 2'b11) & bus.branch_taken));
        tgt_raw = bus.pc_plus_imm;
        if (bus.pc_sel == 2'b10) begin
            tgt_raw = ALIGN_JALR ? {bus.alu_out[31:1], 1'b0} : bus.alu_out;
        end
        tgt = {tgt_raw[31:2], 2'b00};
    end

    assign bus.imem_req_valid = (state == ST_REQ);
    assign bus.imem_addr      = pc;
    // A redirect in OUT means the held word is wrong-path, so hide it the same cycle.
    assign bus.if_valid       = (state == ST_OUT) & ~redir;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.pc_misaligned  = misaligned_q;

    // Fetch sequencing, PC update and wrong-path kill tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            kill       <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    // The request cannot be withdrawn, so a redirect here only marks it stale.
                    if (redir) begin
                        kill    <= 1'b1;
                        pend_pc <= tgt;
                    end
                    if (bus.imem_req_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        kill  <= 1'b0;
                        state <= ST_REQ;
                        if (redir) begin
                            pc <= tgt;
                        end else if (kill) begin
                            pc <= pend_pc;
                        end else begin
                            if_instr_q <= bus.imem_rsp_data;
                            if_pc_q    <= pc;
                            state      <= ST_OUT;
                        end
                    end else if (redir) begin
                        kill    <= 1'b1;
                        pend_pc <= tgt;
                    end
                end
                ST_OUT: begin
                    if (redir) begin
                        pc    <= tgt;
                        state <= ST_REQ;
                    end else if (bus.if_ready) begin
                        pc    <= pc + 32'd4;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle flag when an effective redirect target was not word aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redir & (tgt_raw[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .ALIGN_JALR(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit          m_gap;     // first cycle after reset release
    bit          m_req;     // request open toward imem
    bit          m_await;   // request accepted, word not back yet
    bit          m_hold;    // word held for decode
    bit          m_stale;   // outstanding word is wrong-path
    logic [31:0] m_pc;
    logic [31:0] m_resume;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    bit          m_mis;

    // memory responder
    int          rsp_cnt;
    int          rsp_delay;
    logic [31:0] rsp_addr;

    logic [31:0] issued[$];
    logic [31:0] shown[$];
    int          n_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_gap = 1; m_req = 0; m_await = 0; m_hold = 0; m_stale = 0;
        m_pc = RESET_PC; m_resume = '0; m_instr = '0; m_ipc = '0; m_mis = 0;
    endtask

    // One clock: check outputs against the model for the current inputs,
    // advance the model, then move to the next falling edge.
    task automatic cycle();
        logic [31:0] raw;
        logic [31:0] tgt;
        bit          redir;
        bit          accepted;
        #1;
        redir = bus.redirect_valid &&
                (bus.pc_sel == 2'b01 || bus.pc_sel == 2'b10 ||
                 (bus.pc_sel == 2'b11 && bus.branch_taken));
        raw = (bus.pc_sel == 2'b10) ? bus.alu_out - (bus.alu_out % 2) : bus.pc_plus_imm;
        tgt = raw - (raw % 4);
        accepted = 0;
        if (!rst) begin
            chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
            chk("rst_if_valid", 32'(bus.if_valid), 0);
            chk("rst_if_instr", bus.if_instr, 0);
            chk("rst_if_pc", bus.if_pc, 0);
            chk("rst_misaligned", 32'(bus.pc_misaligned), 0);
            model_reset();
        end else begin
            chk("req_valid", 32'(bus.imem_req_valid), 32'(m_req));
            if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
            chk("if_valid", 32'(bus.if_valid), 32'(m_hold && !redir));
            chk("if_instr", bus.if_instr, m_instr);
            chk("if_pc", bus.if_pc, m_ipc);
            chk("pc_misaligned", 32'(bus.pc_misaligned), 32'(m_mis));
            if (bus.imem_req_valid && bus.imem_req_ready) issued.push_back(bus.imem_addr);
            if (bus.if_valid && bus.if_ready) shown.push_back(bus.if_pc);
            if (bus.pc_misaligned) n_mis++;

            m_mis = redir && (raw % 4 != 0);
            if (m_gap) begin
                m_gap = 0;
                m_req = 1;
            end else if (m_req) begin
                if (redir) begin m_stale = 1; m_resume = tgt; end
                if (bus.imem_req_ready) begin
                    m_req = 0; m_await = 1; accepted = 1; rsp_addr = m_pc;
                end
            end else if (m_await) begin
                if (bus.imem_rsp_valid) begin
                    m_await = 0;
                    if (redir) begin
                        m_pc = tgt; m_stale = 0; m_req = 1;
                    end else if (m_stale) begin
                        m_pc = m_resume; m_stale = 0; m_req = 1;
                    end else begin
                        m_hold = 1; m_instr = mem_word(m_pc); m_ipc = m_pc;
                    end
                end else if (redir) begin
                    m_stale = 1; m_resume = tgt;
                end
            end else if (m_hold) begin
                if (redir) begin
                    m_hold = 0; m_pc = tgt; m_req = 1;
                end else if (bus.if_ready) begin
                    m_hold = 0; m_pc = m_pc + 32'd4; m_req = 1;
                end
            end
        end
        if (rsp_cnt > 0) rsp_cnt--;
        if (accepted) rsp_cnt = (rsp_delay == 0) ? int'($urandom_range(1, 3)) : rsp_delay;
        @(posedge clk);
        @(negedge clk);
        bus.imem_rsp_valid = (rsp_cnt == 1);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(rsp_addr) : $urandom;
    endtask

    task automatic run_until_hold(input string tag);
        for (int i = 0; i < 40 && !m_hold; i++) cycle();
        chk(tag, 32'(m_hold), 1);
    endtask

    task automatic run_until_await(input string tag);
        for (int i = 0; i < 40 && !m_await; i++) cycle();
        chk(tag, 32'(m_await), 1);
    endtask

    task automatic redirect(input logic [1:0] sel, input bit taken,
                            input logic [31:0] imm, input logic [31:0] alu);
        bus.redirect_valid = 1'b1;
        bus.pc_sel         = sel;
        bus.branch_taken   = taken;
        bus.pc_plus_imm    = imm;
        bus.alu_out        = alu;
    endtask

    initial begin
        int          s;
        int          nreq;
        int          mis0;
        logic [31:0] exp_next;
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;

        rst = 1'b0;
        bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
        bus.if_ready = 0; bus.redirect_valid = 0; bus.pc_sel = 2'b00;
        bus.branch_taken = 0; bus.pc_plus_imm = '0; bus.alu_out = '0;
        rsp_cnt = 0; rsp_delay = 1; n_mis = 0;
        model_reset();
        @(negedge clk);
        repeat (3) cycle();

        // sequential fetch from reset
        rst = 1'b1;
        bus.imem_req_ready = 1; bus.if_ready = 1;
        repeat (12) cycle();
        chk("t1_nissued", 32'(issued.size() >= 3), 1);
        chk("t1_addr0", issued[0], RESET_PC);
        chk("t1_addr1", issued[1], RESET_PC + 32'd4);
        chk("t1_addr2", issued[2], RESET_PC + 32'd8);
        chk("t1_pc0", shown[0], RESET_PC);
        chk("t1_pc1", shown[1], RESET_PC + 32'd4);
        chk("t1_pc2", shown[2], RESET_PC + 32'd8);

        // decode stall holds output and blocks new requests
        bus.if_ready = 0;
        run_until_hold("t2_reach_out");
        hold_pc = m_ipc; hold_instr = m_instr; nreq = issued.size();
        repeat (5) cycle();
        chk("t2_pc_stable", bus.if_pc, hold_pc);
        chk("t2_instr_stable", bus.if_instr, hold_instr);
        chk("t2_no_new_req", 32'(issued.size()), 32'(nreq));
        bus.if_ready = 1;
        cycle();

        // jal-style redirect while waiting for a response
        rsp_delay = 3;
        run_until_await("t3_reach_wait");
        s = shown.size();
        redirect(2'b01, 0, 32'h0000_0100, '0);
        cycle();
        bus.redirect_valid = 0;
        for (int i = 0; i < 20 && !m_req; i++) cycle();
        chk("t3_addr", bus.imem_addr, 32'h0000_0100);
        repeat (10) cycle();
        chk("t3_next_shown", shown[s], 32'h0000_0100);

        // untaken branch is a no-op, taken branch in OUT gates if_valid
        rsp_delay = 1;
        run_until_hold("t4_reach_out_a");
        exp_next = m_ipc + 32'd4;
        redirect(2'b11, 0, 32'h0000_0080, '0);
        cycle();
        bus.redirect_valid = 0;
        cycle();
        chk("t4_seq_addr", bus.imem_addr, exp_next);
        run_until_hold("t4_reach_out_b");
        redirect(2'b11, 1, 32'h0000_0040, '0);
        #1;
        chk("t4_if_valid_gated", 32'(bus.if_valid), 0);
        cycle();
        bus.redirect_valid = 0;
        cycle();
        chk("t4_taken_addr", bus.imem_addr, 32'h0000_0040);

        // jalr target cleanup and misaligned flag
        run_until_hold("t5_reach_out");
        mis0 = n_mis;
        redirect(2'b10, 0, '0, 32'h0000_0203);
        cycle();
        bus.redirect_valid = 0;
        cycle();
        chk("t5_addr", bus.imem_addr, 32'h0000_0200);
        repeat (3) cycle();
        chk("t5_mis_pulses", 32'(n_mis - mis0), 1);

        // PC wraps past the top of the address space
        run_until_hold("wrap_reach_out");
        redirect(2'b01, 0, 32'hFFFF_FFFC, '0);
        cycle();
        bus.redirect_valid = 0;
        run_until_hold("wrap_reach_top");
        chk("wrap_top_pc", m_ipc, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // reset mid-request, late response lands in IDLE
        rsp_delay = 8;
        run_until_await("t6_reach_wait");
        rst = 1'b0;
        cycle();
        cycle();
        rsp_cnt = 0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_BAD0;
        bus.imem_req_ready = 0;
        rst = 1'b1;
        cycle();
        repeat (4) cycle();
        chk("t6_addr_stable", bus.imem_addr, RESET_PC);
        chk("t6_req_held", 32'(bus.imem_req_valid), 1);
        bus.imem_req_ready = 1;
        rsp_delay = 1;
        repeat (4) cycle();
        chk("t6_first_shown", bus.if_pc, RESET_PC);

        // randomized traffic
        rsp_delay = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                rsp_cnt = 0;
                bus.imem_rsp_valid = 0;
                cycle();
                cycle();
                rst = 1'b1;
            end
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            bus.if_ready       = ($urandom_range(0, 9) < 6);
            bus.redirect_valid = ($urandom_range(0, 9) < 2);
            bus.pc_sel         = 2'($urandom);
            bus.branch_taken   = 1'($urandom);
            bus.pc_plus_imm    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            bus.alu_out        = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
